// File: rtl/mdu_if.sv
// HI/LO operation bus between the E-stage pipeline register (master) and the
// multiply/divide controller (slave).
interface mdu_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        abort;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;
    logic        busy;
    logic        hilo_busy;

    modport master (
        output start, op, rs_val, rt_val, abort,
        input  hi, lo, rd_data, busy, hilo_busy
    );

    modport slave (
        input  start, op, rs_val, rt_val, abort,
        output hi, lo, rd_data, busy, hilo_busy
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Fixed-latency MIPS multiply/divide controller owning HI/LO.
// Optional feature: define MDU_ABORT_EN to let `abort` cancel an in-flight op.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);
    localparam int DATA_W = 32;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic [DATA_W-1:0]   hi_q, lo_q, hi_nxt, lo_nxt;
    logic                div_zero;
    logic                start_ok, abort_hit;
    logic                is_md, is_mul, is_div;
    logic                load, commit, hi_wr, lo_wr;
    logic [2*DATA_W-1:0] res;

    // Returns {hi, lo} of the 64-bit product.
    function automatic logic [2*DATA_W-1:0] mul_result(
        input logic              is_signed,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [2*DATA_W-1:0] sa, sb;
        sa = is_signed ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
        sb = is_signed ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
        return sa * sb;
    endfunction

    // Returns {remainder, quotient}; a zero divisor yields a don't-care value
    // that is never committed.
    function automatic logic [2*DATA_W-1:0] div_result(
        input logic              is_signed,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] sa, sb, sq, sr;
        if (b == '0) begin
            return '0;
        end else if (is_signed) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return {32'h0, 32'h8000_0000};
            sa = a;
            sb = b;
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end else begin
            return {a % b, a / b};
        end
    endfunction

    assign is_mul = (bus.op == 4'd1) || (bus.op == 4'd2);
    assign is_div = (bus.op == 4'd3) || (bus.op == 4'd4);
    assign is_md  = is_mul || is_div;

`ifdef MDU_ABORT_EN
    assign abort_hit = bus.abort;
    assign start_ok  = bus.start & ~bus.abort;
`else
    // abort has no effect in this build; the AND keeps the port referenced.
    assign abort_hit = bus.abort & 1'b0;
    assign start_ok  = bus.start;
`endif

    always_comb begin
        res = '0;
        if (is_mul)
            res = mul_result(bus.op == 4'd1, bus.rs_val, bus.rt_val);
        else if (is_div)
            res = div_result(bus.op == 4'd3, bus.rs_val, bus.rt_val);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        commit    = 1'b0;
        hi_wr     = 1'b0;
        lo_wr     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    if (is_md) begin
                        load      = 1'b1;
                        state_nxt = S_RUN;
                        cnt_nxt   = is_mul ? 4'(MULT_CYCLES - 1) : 4'(DIV_CYCLES - 1);
                    end
                    hi_wr = (bus.op == 4'd5);
                    lo_wr = (bus.op == 4'd6);
                end
            end
            S_RUN: begin
                if (abort_hit) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == 4'd0) begin
                    commit    = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load)
                div_zero <= is_div && (bus.rt_val == '0);
            if (hi_wr)
                hi_q <= bus.rs_val;
            else if (commit && !div_zero)
                hi_q <= hi_nxt;
            if (lo_wr)
                lo_q <= bus.rs_val;
            else if (commit && !div_zero)
                lo_q <= lo_nxt;
        end
    end

    // Pending result is pure data; it only reaches HI/LO through a RUN commit.
    always_ff @(posedge clk) begin
        if (load) begin
            hi_nxt <= res[2*DATA_W-1:DATA_W];
            lo_nxt <= res[DATA_W-1:0];
        end
    end

    always_comb begin
        case (bus.op)
            4'd7:    bus.rd_data = hi_q;
            4'd8:    bus.rd_data = lo_q;
            default: bus.rd_data = '0;
        endcase
    end

    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.busy      = (state == S_RUN);
    assign bus.hilo_busy = bus.busy | (bus.start & is_md);
endmodule
